// File: rtl/wdata_downsize_seq_if.sv
// Write-data channel bundle for the W-channel downsizer: wide slave-side beat in, narrow beat out.
// When WDS_BEAT_COUNT_EN is defined the bundle also carries m_beat_cnt.
interface wdata_downsize_seq_if #(
    parameter int DATA_WIDTH_IN  = 64,
    parameter int DATA_WIDTH_OUT = 32
);
    localparam int LW = (DATA_WIDTH_IN / DATA_WIDTH_OUT > 1) ? $clog2(DATA_WIDTH_IN / DATA_WIDTH_OUT) : 1;

    logic                        s_wvalid;
    logic                        s_wready;
    logic [DATA_WIDTH_IN-1:0]    s_wdata;
    logic [DATA_WIDTH_IN/8-1:0]  s_wstrb;
    logic                        s_wlast;
    logic [LW-1:0]               s_first_lane;
    logic [LW-1:0]               s_last_lane;
    logic                        m_wvalid;
    logic                        m_wready;
    logic [DATA_WIDTH_OUT-1:0]   m_wdata;
    logic [DATA_WIDTH_OUT/8-1:0] m_wstrb;
    logic [DATA_WIDTH_OUT-1:0]   m_wmask;
    logic                        m_wlast;
    logic                        busy;
`ifdef WDS_BEAT_COUNT_EN
    logic [7:0]                  m_beat_cnt;
`endif

    // Seen from the downsizer: consumes the wide beat, produces the narrow beats.
    modport slave (
        input  s_wvalid, s_wdata, s_wstrb, s_wlast, s_first_lane, s_last_lane, m_wready,
        output s_wready, m_wvalid, m_wdata, m_wstrb, m_wmask, m_wlast, busy
`ifdef WDS_BEAT_COUNT_EN
        , output m_beat_cnt
`endif
    );

    modport master (
        output s_wvalid, s_wdata, s_wstrb, s_wlast, s_first_lane, s_last_lane, m_wready,
        input  s_wready, m_wvalid, m_wdata, m_wstrb, m_wmask, m_wlast, busy
`ifdef WDS_BEAT_COUNT_EN
        , input m_beat_cnt
`endif
    );
endinterface

// File: rtl/wdata_downsize_seq.sv
// Splits one held wide AXI4 W beat into a run of narrow beats, lane first..last, with byte mask.
// Optional WDS_BEAT_COUNT_EN adds a saturating per-burst narrow handshake counter (m_beat_cnt).
module wds_byte_mask (
    input  logic       strb,
    output logic [7:0] mask
);
    assign mask = {8{strb}};
endmodule

module wdata_downsize_seq #(
    parameter int DATA_WIDTH_IN  = 64,
    parameter int DATA_WIDTH_OUT = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    wdata_downsize_seq_if.slave   bus
);
    localparam int RATIO  = DATA_WIDTH_IN / DATA_WIDTH_OUT;
    localparam int LW     = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int SW_IN  = DATA_WIDTH_IN / 8;
    localparam int SW_OUT = DATA_WIDTH_OUT / 8;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                   state_q, state_d;
    logic [DATA_WIDTH_IN-1:0] data_q, data_d;
    logic [SW_IN-1:0]         strb_q, strb_d;
    logic                     last_q, last_d;
    logic [LW-1:0]            lane_q, lane_d;
    logic [LW-1:0]            last_lane_q, last_lane_d;

    logic [DATA_WIDTH_OUT-1:0] sel_data;
    logic [SW_OUT-1:0]         sel_strb;
    logic [SW_OUT-1:0][7:0]    sel_mask;
    logic                      final_lane;
    logic                      m_hs;
    logic                      s_rdy;
    logic [LW-1:0]             first_m, last_m;

    function automatic logic [LW-1:0] lane_mod(input logic [LW-1:0] l);
        int unsigned v;
        v = 32'(l) % RATIO;
        return v[LW-1:0];
    endfunction

    assign first_m    = lane_mod(bus.s_first_lane);
    assign last_m     = lane_mod(bus.s_last_lane);
    assign final_lane = (lane_q == last_lane_q);
    assign m_hs       = (state_q == SEND) && bus.m_wready;
    // The final-lane handshake frees the holding regs, so the next wide beat can load in the same cycle.
    assign s_rdy      = (state_q == IDLE) || (m_hs && final_lane);

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        strb_d      = strb_q;
        last_d      = last_q;
        lane_d      = lane_q;
        last_lane_d = last_lane_q;
        if (m_hs && !final_lane) begin
            lane_d = lane_q + LW'(1);
        end else if (s_rdy && bus.s_wvalid) begin
            state_d     = SEND;
            data_d      = bus.s_wdata;
            strb_d      = bus.s_wstrb;
            last_d      = bus.s_wlast;
            lane_d      = first_m;
            // A reversed lane range collapses to a single beat on the first lane.
            last_lane_d = (first_m > last_m) ? first_m : last_m;
        end else if (m_hs) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= IDLE;
            data_q      <= '0;
            strb_q      <= '0;
            last_q      <= 1'b0;
            lane_q      <= '0;
            last_lane_q <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            strb_q      <= strb_d;
            last_q      <= last_d;
            lane_q      <= lane_d;
            last_lane_q <= last_lane_d;
        end
    end

    always_comb begin
        sel_data = '0;
        sel_strb = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (lane_q == LW'(i)) begin
                sel_data = data_q[i*DATA_WIDTH_OUT +: DATA_WIDTH_OUT];
                sel_strb = strb_q[i*SW_OUT +: SW_OUT];
            end
        end
    end

    for (genvar b = 0; b < SW_OUT; b++) begin : g_mask
        wds_byte_mask u_mask (
            .strb (sel_strb[b]),
            .mask (sel_mask[b])
        );
    end

    assign bus.s_wready = s_rdy;
    assign bus.m_wvalid = (state_q == SEND);
    assign bus.m_wdata  = sel_data;
    assign bus.m_wstrb  = sel_strb;
    assign bus.m_wmask  = sel_mask;
    assign bus.m_wlast  = (state_q == SEND) && last_q && final_lane;
    assign bus.busy     = (state_q == SEND);

`ifdef WDS_BEAT_COUNT_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (m_hs) begin
            if (bus.m_wlast)          cnt_d = 8'd0;
            else if (cnt_q != 8'hFF)  cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) cnt_q <= 8'd0;
        else        cnt_q <= cnt_d;
    end

    assign bus.m_beat_cnt = cnt_q;
`endif
endmodule
